sort_batch_controller: RTL and testbench
========================================

Name: sort_batch_controller

Overview:
- Sequences the 16-input, 32-bit SortingNetwork as a streaming resource.
- Collects words from an upstream valid/ready stream into a 16-entry batch and pads short batches.
- Pulses the network's reset, holds its enable until it reports valid, then drains only the real (non-pad) sorted results downstream with a last marker.
- Sits between the system data stream and the SortingNetwork instance.

Parameters:
- N, 16, batch size; fixed by the network's port count, not to be overridden.
- DW, 32, element width.
- PAD_VALUE, 32'hFFFF_FFFF, fill value for unused slots; largest unsigned value, so pads sort to the top.
- TIMEOUT_CYCLES, 64, maximum cycles to wait for sn_valid (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- in_data  in  DW  upstream element.
- in_valid  in  1  upstream element valid.
- in_ready  out  1  controller accepts an element.
- in_last  in  1  qualifies in_data as the final element of a batch (short-batch flush).
- out_data  out  DW  sorted element.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  final real element of the batch.
- sn_din  out  N*DW  packed network inputs; slot i at bits [i*DW +: DW].
- sn_ena  out  1  network enable.
- sn_rst  out  1  network reset, active-low.
- sn_dout  in  N*DW  packed network outputs; slot 0 is the smallest.
- sn_valid  in  1  network result valid.
- busy  out  1  high in any state other than LOAD with count==0.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset values: all outputs 0 except sn_rst=1. Internal state: state=LOAD, count=0, rd_idx=0, all buffers =PAD_VALUE.
- States: LOAD, SN_RST, SORT, DRAIN.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: buf[count]<=in_data; count<=count+1.
  - When the accepted word is the 16th (count==15), or in_last=1, go to SN_RST. Slots >= the new count already hold PAD_VALUE.
  - in_last on the 16th word is identical to a full batch.
  - in_last without in_valid is ignored.
- sn_din is driven combinationally from buf, stable from SN_RST through SORT.
- SN_RST:
  - Exactly one cycle, sn_rst=0, sn_ena=0, in_ready=0.
  - Then SORT.
- SORT:
  - sn_ena=1 held until sn_valid is sampled 1.
  - That cycle: res<=sn_dout; sn_ena deasserts next cycle; go to DRAIN.
  - Minimum latency from the final input handshake to the first out_valid: 3 cycles plus the network latency.
- DRAIN:
  - out_valid=1; out_data=res[rd_idx]; out_last=(rd_idx==count-1). out_data, out_valid and out_last are registered.
  - Advance only on out_valid&out_ready, and hold stable otherwise.
  - After the last handshake: count<=0, rd_idx<=0, buf reset to PAD_VALUE, go to LOAD.
  - in_ready stays 0 throughout DRAIN (no batch overlap).
  - The first in_ready is the cycle after the last output handshake.
- Pads are never emitted, including real data equal to PAD_VALUE: the first count entries are emitted, and ties are value-identical.
- count is a 5-bit counter (0..16); rd_idx is 4-bit. No wrap: count never exceeds 16.
- Asynchronous reset mid-operation (any state): immediate return to reset values. The partial batch is discarded, sn_ena drops, and err clears.

Optional Feature:
- Macro: SORT_BATCH_TIMEOUT_EN.
- Defined:
  - A timer clears on SORT entry and increments each SORT cycle.
  - If it reaches TIMEOUT_CYCLES without sn_valid: err<=1 (sticky until rst), sn_ena<=0, and the batch is discarded (count, buf reset) with return to LOAD.
- Undefined:
  - SORT waits indefinitely; err tied to 0; no timer logic.

Decomposition:
- Shared package sort_pkg holds:
  - N and DW constants.
  - PAD_VALUE.
  - The state enum {LOAD, SN_RST, SORT, DRAIN}.
  - Slot-index helper width constants.
- One natural sub-module: sort_batch_buffer, the N x DW register file with write index, PAD clear and packed output, instantiated twice (buf, res).
- The FSM stays in the top.

Test Plan:
- Full batch, 16 descending values 16..1 with out_ready=1 -> one sn_rst low cycle, sn_ena high until sn_valid; outputs 1..16 on consecutive cycles, out_last only with 16.
- Short batch 3524, 242, 9132, 7132, 9381, in_last on 9381 -> sn_din slots 5..15 = FFFF_FFFF; outputs exactly 242, 3524, 7132, 9132, 9381, out_last on 9381, no pads emitted.
- Single element 7 with in_last -> one output 7 with out_last=1; in_ready returns 1 the next cycle.
- out_ready toggled 1,0,0,1,... in DRAIN -> out_data held stable while stalled; order and count unchanged; in_ready stays 0 until the final handshake.
- rst pulsed low during DRAIN after 3 outputs -> all outputs return to reset values immediately; the next batch sorts correctly from count=0.
- With SORT_BATCH_TIMEOUT_EN and sn_valid held 0 -> after 64 SORT cycles err=1, sn_ena=0, in_ready=1; a following batch completes normally with err still 1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared constants and types for the sort batch controller.
// Batch geometry, pad value, slot-index widths and the controller state encoding.
package sort_pkg;

  localparam int N     = 16;
  localparam int DW    = 32;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = IDX_W + 1;

  // Largest unsigned value: pads always sort to the top of the network.
  localparam logic [DW-1:0] PAD_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD,
    SN_RST,
    SORT,
    DRAIN
  } state_t;

endpackage

// File: rtl/sort_batch_buffer.sv
// N x DW register file with a single-slot write port, a full-width load port
// and a clear that refills every slot with PAD_VALUE. Contents are exposed
// packed, slot i at bits [i*DW +: DW].
module sort_batch_buffer
  import sort_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DW-1:0]     i_wr_data,
  input  logic              i_ld_en,
  input  logic [N*DW-1:0]   i_ld_data,
  input  logic              i_clr,
  output logic [N*DW-1:0]   o_data
);

  logic [N*DW-1:0] r_mem;

  // Clear has priority, then full load, then single-slot write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= {N{PAD_VALUE}};
    end else if (i_clr) begin
      r_mem <= {N{PAD_VALUE}};
    end else if (i_ld_en) begin
      r_mem <= i_ld_data;
    end else if (i_wr_en) begin
      r_mem[i_wr_idx*DW +: DW] <= i_wr_data;
    end
  end

  assign o_data = r_mem;

endmodule

// File: rtl/sort_batch_controller.sv
// Streams batches of up to N words through an external N-input sorting
// network: collects words (padding short batches), pulses the network reset,
// holds enable until the result is valid, then drains only the real results
// downstream with a last marker.
// Optional feature macro: SORT_BATCH_TIMEOUT_EN (bounded wait for sn_valid,
// sticky err, batch discarded on expiry).
module sort_batch_controller
  import sort_pkg::*;
`ifdef SORT_BATCH_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = 64
)
`endif
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [N*DW-1:0]   sn_din,
  output logic              sn_ena,
  output logic              sn_rst,
  input  logic [N*DW-1:0]   sn_dout,
  input  logic              sn_valid,
  output logic              busy,
  output logic              err
);

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_rd_idx;
  logic [IDX_W-1:0]  w_rd_next;
  logic              r_run;
  logic [DW-1:0]     r_out_data;
  logic              r_out_valid;
  logic              r_out_last;
  logic [N*DW-1:0]   w_res;
  logic              w_accept;
  logic              w_out_fire;
  logic              w_last_out;
  logic              w_timeout;
  logic              w_in_ready;
  logic              w_sn_ena;
  logic              w_sn_rst;
  logic              w_buf_clr;
  logic              w_res_ld;

  assign w_accept   = (r_state == LOAD) && r_run && in_valid;
  assign w_out_fire = r_out_valid && out_ready;
  assign w_last_out = ({1'b0, r_rd_idx} == (r_count - CNT_W'(1)));
  assign w_rd_next  = r_rd_idx + IDX_W'(1);

  // Input collection buffer; its contents feed the network directly.
  sort_batch_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .i_wr_en   (w_accept),
    .i_wr_idx  (r_count[IDX_W-1:0]),
    .i_wr_data (in_data),
    .i_ld_en   (1'b0),
    .i_ld_data ({N*DW{1'b0}}),
    .i_clr     (w_buf_clr),
    .o_data    (sn_din)
  );

  // Captured network result, read back one slot per output handshake.
  sort_batch_buffer u_res (
    .clk       (clk),
    .rst_n     (rst),
    .i_wr_en   (1'b0),
    .i_wr_idx  ({IDX_W{1'b0}}),
    .i_wr_data ({DW{1'b0}}),
    .i_ld_en   (w_res_ld),
    .i_ld_data (sn_dout),
    .i_clr     (w_buf_clr),
    .o_data    (w_res)
  );

  // Holds in_ready low while reset is asserted and for the first cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_run <= 1'b0;
    else      r_run <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LOAD;
    else      r_state <= w_next_state;
  end

  // Next-state and per-state control strobes.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_sn_ena     = 1'b0;
    w_sn_rst     = 1'b1;
    w_buf_clr    = 1'b0;
    w_res_ld     = 1'b0;
    case (r_state)
      LOAD: begin
        w_in_ready = r_run;
        if (w_accept && ((r_count == CNT_W'(N-1)) || in_last))
          w_next_state = SN_RST;
      end
      SN_RST: begin
        w_sn_rst     = 1'b0;
        w_next_state = SORT;
      end
      SORT: begin
        w_sn_ena = 1'b1;
        if (sn_valid) begin
          w_res_ld     = 1'b1;
          w_next_state = DRAIN;
        end else if (w_timeout) begin
          w_buf_clr    = 1'b1;
          w_next_state = LOAD;
        end
      end
      DRAIN: begin
        if (w_out_fire && w_last_out) begin
          w_buf_clr    = 1'b1;
          w_next_state = LOAD;
        end
      end
      default: w_next_state = LOAD;
    endcase
  end

  // Batch count, read index and the registered output stage. The first
  // result is taken straight from sn_dout so DRAIN starts with data ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= '0;
      r_rd_idx    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_accept) r_count <= r_count + CNT_W'(1);
        end
        SORT: begin
          if (sn_valid) begin
            r_rd_idx    <= '0;
            r_out_data  <= sn_dout[DW-1:0];
            r_out_valid <= 1'b1;
            r_out_last  <= (r_count == CNT_W'(1));
          end else if (w_timeout) begin
            r_count <= '0;
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            if (w_last_out) begin
              r_count     <= '0;
              r_rd_idx    <= '0;
              r_out_data  <= '0;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_rd_idx    <= w_rd_next;
              r_out_data  <= w_res[w_rd_next*DW +: DW];
              r_out_last  <= ({1'b0, w_rd_next} == (r_count - CNT_W'(1)));
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SORT_BATCH_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] r_timer;
  logic             r_err;

  assign w_timeout = (r_state == SORT) && !sn_valid &&
                     (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));

  // SORT-cycle timer (cleared on the way into SORT) and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == SN_RST)    r_timer <= '0;
      else if (r_state == SORT) r_timer <= r_timer + TMR_W'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign in_ready  = w_in_ready;
  assign sn_ena    = w_sn_ena;
  assign sn_rst    = w_sn_rst;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = !((r_state == LOAD) && (r_count == '0));

endmodule

// File: tb/tb_sort_batch_controller.sv
// Testbench for sort_batch_controller: behavioural sorting-network model,
// table of directed batches, hand-written stall/reset/timeout sequences and
// randomized batches checked against a queue-sort reference.
`timescale 1ns/1ps
module tb_sort_batch_controller;
  import sort_pkg::*;

  localparam int NET_LAT = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            out_last;
  logic [N*DW-1:0] sn_din;
  logic            sn_ena;
  logic            sn_rst;
  logic [N*DW-1:0] sn_dout;
  logic            sn_valid;
  logic            busy;
  logic            err;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   net_stall = 1'b0;
  int   net_cnt = 0;
  logic exp_err = 1'b0;

  sort_batch_controller dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .sn_din(sn_din), .sn_ena(sn_ena), .sn_rst(sn_rst),
    .sn_dout(sn_dout), .sn_valid(sn_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Sorting network model: full ascending sort, valid NET_LAT cycles after enable.
  function automatic logic [N*DW-1:0] net_sort(input logic [N*DW-1:0] d);
    logic [DW-1:0] a [N];
    logic [DW-1:0] t;
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) a[i] = d[i*DW +: DW];
    for (int i = 1; i < N; i++) begin
      t = a[i];
      for (int j = i; j > 0; j--) begin
        if (a[j-1] > t) begin a[j] = a[j-1]; a[j-1] = t; end
      end
    end
    for (int i = 0; i < N; i++) r[i*DW +: DW] = a[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!sn_rst || !sn_ena) net_cnt <= 0;
    else                    net_cnt <= net_cnt + 1;
  end
  assign sn_valid = !net_stall && sn_ena && (net_cnt >= NET_LAT);
  assign sn_dout  = net_sort(sn_din);

  // Reference: the real words of the batch in ascending order.
  function automatic logic [15:0][31:0] ref_sort(input logic [15:0][31:0] v, input int n);
    logic [31:0] q[$];
    logic [15:0][31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) q.push_back(v[i]);
    q.sort();
    for (int i = 0; i < n; i++) r[i] = q[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic pat(input int orm, input int p);
    if (orm == 0) return 1'b1;
    if (orm == 1) return (p % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic send_batch(input string tag, input logic [15:0][31:0] v, input int n,
                            input bit lastf, input bit gaps, output bit ok);
    int tmo;
    ok = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));
          in_data  = $urandom;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = lastf && (i == n - 1);
      tmo = 0;
      @(negedge clk);
      while (!in_ready && tmo < 50) begin tmo++; @(negedge clk); end
      if (tmo >= 50) begin
        check({tag, ".in_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0; in_last = 1'b0;
        ok = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_batch(input string tag, input logic [15:0][31:0] v, input int n,
                           input bit lastf, input int orm, input bit gaps,
                           input logic [15:0][31:0] e);
    int k, cyc, rstlow, ena, first, p;
    bit done, ok;
    p = 0;
    out_ready = pat(orm, p);
    send_batch(tag, v, n, lastf, gaps, ok);
    if (!ok) return;
    k = 0; cyc = 0; rstlow = 0; ena = 0; first = -1; done = 1'b0;
    while (!done && cyc < 500) begin
      @(negedge clk); cyc++;
      if (!sn_rst) begin
        rstlow++;
        for (int s = 0; s < N; s++)
          check($sformatf("%s.sn_din%0d", tag, s), sn_din[s*DW +: DW],
                (s < n) ? v[s] : PAD_VALUE);
      end
      if (sn_ena) ena++;
      check({tag, ".busy"}, 32'(busy), 32'd1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        check($sformatf("%s.data%0d", tag, k), out_data, e[k]);
        check($sformatf("%s.last%0d", tag, k), 32'(out_last), 32'(k == n - 1));
        check({tag, ".in_ready_drain"}, 32'(in_ready), 32'd0);
        if (out_ready) begin k++; if (k == n) done = 1'b1; end
      end
      @(posedge clk); #1;
      p++;
      out_ready = pat(orm, p);
    end
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".sn_rst_cycles"}, 32'(rstlow), 32'd1);
    check({tag, ".sn_ena_cycles"}, 32'(ena), 32'(NET_LAT + 1));
    check({tag, ".latency"}, 32'(first), 32'(3 + NET_LAT));
    check({tag, ".err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, ".in_ready_after"}, 32'(in_ready), 32'd1);
    check({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    check({tag, ".busy_after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    string             name;
    int                n;
    logic [15:0][31:0] v;
    bit                lst;
    int                orm;
    logic [15:0][31:0] e;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int s1[5], e1[5], v3[6], v4[4], e4[4], e5[16];
    logic [15:0][31:0] rv, re;
    int n, got, cyc;
    bit lastf, ok;

    s1 = '{3524, 242, 9132, 7132, 9381};
    e1 = '{242, 3524, 7132, 9132, 9381};
    v3 = '{50, 10, 40, 20, 60, 30};
    v4 = '{-1, 5, -1, 0};
    e4 = '{0, 5, -1, -1};
    e5 = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4};

    foreach (tbl[t]) begin tbl[t].v = '0; tbl[t].e = '0; tbl[t].orm = 0; tbl[t].lst = 1'b1; end
    tbl[0].name = "full_desc"; tbl[0].n = 16; tbl[0].lst = 1'b0;
    for (int i = 0; i < 16; i++) begin tbl[0].v[i] = 32'(16 - i); tbl[0].e[i] = 32'(i + 1); end
    tbl[1].name = "short5"; tbl[1].n = 5;
    for (int i = 0; i < 5; i++) begin tbl[1].v[i] = 32'(s1[i]); tbl[1].e[i] = 32'(e1[i]); end
    tbl[2].name = "single"; tbl[2].n = 1; tbl[2].v[0] = 32'd7; tbl[2].e[0] = 32'd7;
    tbl[3].name = "stall"; tbl[3].n = 6; tbl[3].orm = 1;
    for (int i = 0; i < 6; i++) begin tbl[3].v[i] = 32'(v3[i]); tbl[3].e[i] = 32'(10 * (i + 1)); end
    tbl[4].name = "pad_data"; tbl[4].n = 4;
    for (int i = 0; i < 4; i++) begin tbl[4].v[i] = 32'(v4[i]); tbl[4].e[i] = 32'(e4[i]); end
    tbl[5].name = "full_last_ties"; tbl[5].n = 16;
    for (int i = 0; i < 16; i++) begin tbl[5].v[i] = 32'((2 * i) % 5); tbl[5].e[i] = 32'(e5[i]); end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data",  out_data,       32'd0);
    check("rst.out_last",  32'(out_last),  32'd0);
    check("rst.sn_ena",    32'(sn_ena),    32'd0);
    check("rst.sn_rst",    32'(sn_rst),    32'd1);
    check("rst.busy",      32'(busy),      32'd0);
    check("rst.err",       32'(err),       32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Directed table
    for (int t = 0; t < 6; t++)
      run_batch(tbl[t].name, tbl[t].v, tbl[t].n, tbl[t].lst, tbl[t].orm, 1'b0, tbl[t].e);

    // Reset asserted in DRAIN after three outputs, then a fresh batch
    for (int i = 0; i < 16; i++) rv[i] = 32'(100 - 3 * i);
    out_ready = 1'b1;
    send_batch("mid_rst", rv, 8, 1'b1, 1'b0, ok);
    got = 0; cyc = 0;
    while (got < 3 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (out_valid && out_ready) got++;
    end
    check("mid_rst.outputs_seen", 32'(got), 32'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.out_data",  out_data,       32'd0);
    check("mid_rst.out_last",  32'(out_last),  32'd0);
    check("mid_rst.sn_ena",    32'(sn_ena),    32'd0);
    check("mid_rst.sn_rst",    32'(sn_rst),    32'd1);
    check("mid_rst.in_ready",  32'(in_ready),  32'd0);
    check("mid_rst.busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) rv[i] = 32'((i * 37) % 11);
    run_batch("after_rst", rv, 5, 1'b1, 0, 1'b0, ref_sort(rv, 5));

    // Randomized batches with input gaps and random backpressure
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++)
        rv[i] = ($urandom_range(0, 5) == 0) ? PAD_VALUE :
                (($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) : $urandom);
      lastf = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
      re = ref_sort(rv, n);
      run_batch($sformatf("rnd%0d", r), rv, n, lastf, 2, 1'b1, re);
    end

`ifdef SORT_BATCH_TIMEOUT_EN
    // Network never reports valid: timeout discards the batch
    net_stall = 1'b1;
    for (int i = 0; i < 16; i++) rv[i] = 32'(i + 1);
    send_batch("tmo", rv, 4, 1'b1, 1'b0, ok);
    got = 0; cyc = 0;
    while (cyc < 300) begin
      @(negedge clk); cyc++;
      if (in_ready) break;
      if (sn_ena) got++;
    end
    check("tmo.sn_ena_cycles", 32'(got),      32'd64);
    check("tmo.err",           32'(err),      32'd1);
    check("tmo.in_ready",      32'(in_ready), 32'd1);
    check("tmo.sn_ena",        32'(sn_ena),   32'd0);
    check("tmo.busy",          32'(busy),     32'd0);
    net_stall = 1'b0;
    exp_err = 1'b1;
    for (int i = 0; i < 16; i++) rv[i] = 32'(50 - i);
    run_batch("after_tmo", rv, 7, 1'b1, 0, 1'b0, ref_sort(rv, 7));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
